// File: rtl/mux_n_to_1_pipe.sv
// ---------------------------------------------------------------------------
// mux_n_to_1_pipe
//
// Purpose:
//   N-input, WIDTH-bit multiplexer with a registered output, a valid/ready
//   handshake on both sides and a 2-entry skid buffer (main + skid). The
//   upstream ready is a register, so it never depends combinationally on
//   Out_Ready. A one-cycle downstream stall is absorbed by the skid entry.
//
// Parameters:
//   WIDTH  data width of each input and of the output
//   N      number of inputs (2..16)
//   SEL_W  select width, 2**SEL_W >= N
//
// Ports:
//   Clk        rising-edge clock
//   Reset      synchronous active-high reset (priority over Flush)
//   In_Data    flattened inputs, input i at [i*WIDTH +: WIDTH]
//   Sel        input select, sampled with In_Valid
//   In_Valid   upstream offers In_Data/Sel
//   In_Ready   registered; 1 while a free entry exists
//   Flush      discard all buffered entries (priority over accept/pop)
//   Mux_Out    registered selected data (main entry)
//   Out_Valid  Mux_Out holds a valid entry
//   Out_Ready  downstream consumes Mux_Out this cycle
//   Sel_Err    sticky out-of-range select flag
//
// Build option:
//   MUX_SEL_CHECK_EN  when defined, an accepted Sel >= N sets Sel_Err until
//                     Reset. When undefined, Sel_Err is constant 0 and no
//                     compare logic is built. The data path stores slice 0
//                     for an out-of-range Sel in both builds.
// ---------------------------------------------------------------------------
module mux_n_to_1_pipe #(
  parameter int WIDTH = 5,
  parameter int N     = 2,
  parameter int SEL_W = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [N*WIDTH-1:0]   In_Data,
  input  logic [SEL_W-1:0]     Sel,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic                 Flush,
  output logic [WIDTH-1:0]     Mux_Out,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic                 Sel_Err
);

  localparam int SEL_SPAN = 1 << SEL_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // Every select code maps to a slice; codes >= N fall back to slice 0,
  // so the read is a plain table index with no runtime compare.
  logic [WIDTH-1:0] slice_tbl [SEL_SPAN];
  logic [WIDTH-1:0] sel_data;

  for (genvar gi = 0; gi < SEL_SPAN; gi++) begin : g_slice
    if (gi < N) begin : g_in
      assign slice_tbl[gi] = In_Data[gi*WIDTH +: WIDTH];
    end else begin : g_fallback
      assign slice_tbl[gi] = In_Data[0 +: WIDTH];
    end
  end

  assign sel_data = slice_tbl[Sel];

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             accept;
  logic             pop;

  assign accept = In_Valid & in_ready_q;
  assign pop    = out_valid_q & Out_Ready;

  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    if (Flush) begin
      // Buffered entries are dropped; main keeps its stale value since
      // Mux_Out is don't-care while Out_Valid is low.
      state_d     = ST_EMPTY;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d      = sel_data;
            state_d     = ST_ONE;
            out_valid_d = 1'b1;
            in_ready_d  = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            main_d = sel_data;
          end else if (accept) begin
            // Downstream stalled: park the new entry, stop accepting.
            skid_d     = sel_data;
            state_d    = ST_TWO;
            in_ready_d = 1'b0;
          end else if (pop) begin
            state_d     = ST_EMPTY;
            out_valid_d = 1'b0;
          end
        end
        ST_TWO: begin
          // In_Ready is low here, so only a pop can happen.
          if (pop) begin
            main_d     = skid_q;
            state_d    = ST_ONE;
            in_ready_d = 1'b1;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign Mux_Out   = main_q;
  assign Out_Valid = out_valid_q;
  assign In_Ready  = in_ready_q;

`ifdef MUX_SEL_CHECK_EN
  // Per-code out-of-range flag, fixed at elaboration.
  logic [SEL_SPAN-1:0] oob_tbl;
  logic                sel_err_q, sel_err_d;

  for (genvar gi = 0; gi < SEL_SPAN; gi++) begin : g_oob
    if (gi < N) begin : g_ok
      assign oob_tbl[gi] = 1'b0;
    end else begin : g_bad
      assign oob_tbl[gi] = 1'b1;
    end
  end

  always_comb begin
    sel_err_d = sel_err_q;
    // An accept discarded by Flush does not count as a stored entry.
    if (accept && !Flush && oob_tbl[Sel]) begin
      sel_err_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign Sel_Err = sel_err_q;
`else
  assign Sel_Err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_n_to_1_pipe.sv
// ---------------------------------------------------------------------------
// tb_mux_n_to_1_pipe
//
// Directed bench for mux_n_to_1_pipe with WIDTH=32, N=3, SEL_W=2, so that
// select code 3 exercises the out-of-range fallback to slice 0. Inputs are
// driven 1 time unit after the rising edge; outputs are sampled at the same
// point, i.e. they show the result of the edge just passed.
// ---------------------------------------------------------------------------
module tb_mux_n_to_1_pipe;

  localparam int WIDTH = 32;
  localparam int N     = 3;
  localparam int SEL_W = 2;

`ifdef MUX_SEL_CHECK_EN
  localparam bit SEL_CHK = 1'b1;
`else
  localparam bit SEL_CHK = 1'b0;
`endif

  logic                 Clk = 1'b0;
  logic                 Reset;
  logic [N*WIDTH-1:0]   In_Data;
  logic [SEL_W-1:0]     Sel;
  logic                 In_Valid;
  logic                 In_Ready;
  logic                 Flush;
  logic [WIDTH-1:0]     Mux_Out;
  logic                 Out_Valid;
  logic                 Out_Ready;
  logic                 Sel_Err;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  mux_n_to_1_pipe #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .In_Data   (In_Data),
    .Sel       (Sel),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Flush     (Flush),
    .Mux_Out   (Mux_Out),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Sel_Err   (Sel_Err)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_data(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                          input logic [WIDTH-1:0] d2);
    In_Data = {d2, d1, d0};
  endtask

  task automatic idle();
    In_Valid  = 1'b0;
    Flush     = 1'b0;
    Reset     = 1'b0;
    Out_Ready = 1'b1;
    Sel       = '0;
  endtask

  // Reset from idle, then again with an entry in flight and a new offer.
  task automatic test_reset();
    Reset = 1'b1; Flush = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b1; Sel = '0;
    set_data(0, 0, 0);
    step(); step();
    Reset = 1'b0;
    checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL rst_idle_valid: got %0b want 0", Out_Valid); end
    checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL rst_idle_ready: got %0b want 1", In_Ready); end
    set_data(5, 6, 7); Sel = 2'd1; In_Valid = 1'b1;
    step();
    checks++; if (Out_Valid !== 1'b1 || Mux_Out !== 32'd6) begin errors++; $display("FAIL rst_preload: got v=%0b d=%0d want v=1 d=6", Out_Valid, Mux_Out); end
    Out_Ready = 1'b0; Reset = 1'b1;
    step();
    Reset = 1'b0; In_Valid = 1'b0;
    checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %0b want 0", Out_Valid); end
    checks++; if (Mux_Out !== 32'd0) begin errors++; $display("FAIL rst_mid_data: got %0d want 0", Mux_Out); end
    checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %0b want 1", In_Ready); end
    checks++; if (Sel_Err !== 1'b0) begin errors++; $display("FAIL rst_mid_selerr: got %0b want 0", Sel_Err); end
    $display("txn reset: Out_Valid=%0b Mux_Out=%0d In_Ready=%0b", Out_Valid, Mux_Out, In_Ready);
  endtask

  // Slices {2:0, 1:15, 0:1}; Sel=0 then Sel=1 with downstream always ready.
  task automatic test_basic_select();
    idle();
    set_data(32'd1, 32'd15, 32'd0);
    Sel = 2'd0; In_Valid = 1'b1;
    step();
    checks++; if (Out_Valid !== 1'b1 || Mux_Out !== 32'd1) begin errors++; $display("FAIL basic_sel0: got v=%0b d=%0d want v=1 d=1", Out_Valid, Mux_Out); end
    $display("txn basic: sel=0 out=%0d", Mux_Out);
    Sel = 2'd1;
    step();
    checks++; if (Out_Valid !== 1'b1 || Mux_Out !== 32'd15) begin errors++; $display("FAIL basic_sel1: got v=%0b d=%0d want v=1 d=15", Out_Valid, Mux_Out); end
    checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %0b want 1", In_Ready); end
    $display("txn basic: sel=1 out=%0d", Mux_Out);
    In_Valid = 1'b0;
    step();
    checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %0b want 0", Out_Valid); end
  endtask

  // Stream 10..13 on slice 0, Out_Ready low for the two cycles after the
  // first accept. Expected In_Ready after each edge is hand-traced.
  task automatic test_stall_skid();
    logic [WIDTH-1:0] vals [4];
    bit               or_pat [8];
    bit               exp_rdy [7];
    int               sent;
    int               got;
    bit               acc;
    vals    = '{32'd10, 32'd11, 32'd12, 32'd13};
    or_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    sent = 0; got = 0;
    idle();
    for (int cyc = 0; cyc < 10; cyc++) begin
      In_Valid = (sent < 4);
      set_data((sent < 4) ? vals[sent] : 32'd0, 32'd99, 32'd98);
      Sel = 2'd0;
      Out_Ready = (cyc < 8) ? or_pat[cyc] : 1'b1;
      acc = In_Valid && In_Ready;
      if (Out_Valid && Out_Ready) begin
        checks++;
        if (got >= 4) begin
          errors++; $display("FAIL stall_extra: got extra output %0d want none", Mux_Out);
        end else if (Mux_Out !== vals[got]) begin
          errors++; $display("FAIL stall_order: got %0d want %0d", Mux_Out, vals[got]);
        end
        $display("txn stall: pop %0d", Mux_Out);
        got++;
      end
      step();
      if (acc) sent++;
      if (cyc < 7) begin
        checks++; if (In_Ready !== exp_rdy[cyc]) begin errors++; $display("FAIL stall_ready_c%0d: got %0b want %0b", cyc, In_Ready, exp_rdy[cyc]); end
      end
    end
    checks++; if (got !== 4) begin errors++; $display("FAIL stall_count: got %0d outputs want 4", got); end
    In_Valid = 1'b0;
  endtask

  // Flush in ONE with an acceptable offer, and in TWO with a blocked offer.
  task automatic test_flush();
    idle();
    Out_Ready = 1'b0; Sel = 2'd0;
    set_data(32'd24, 0, 0); In_Valid = 1'b1;
    step();
    Flush = 1'b1; set_data(32'd25, 0, 0);
    step();
    Flush = 1'b0; In_Valid = 1'b0;
    checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL flush_one_valid: got %0b want 0", Out_Valid); end
    set_data(32'd20, 0, 0); In_Valid = 1'b1;
    step();
    set_data(32'd21, 0, 0);
    step();
    checks++; if (In_Ready !== 1'b0 || Out_Valid !== 1'b1) begin errors++; $display("FAIL flush_two_setup: got rdy=%0b v=%0b want rdy=0 v=1", In_Ready, Out_Valid); end
    Flush = 1'b1; set_data(32'd22, 0, 0);
    step();
    Flush = 1'b0; In_Valid = 1'b0;
    checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL flush_two_valid: got %0b want 0", Out_Valid); end
    checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL flush_two_ready: got %0b want 1", In_Ready); end
    Out_Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL flush_leak_%0d: got v=%0b d=%0d want v=0", i, Out_Valid, Mux_Out); end
    end
    set_data(32'd23, 0, 0); In_Valid = 1'b1;
    step();
    In_Valid = 1'b0;
    checks++; if (Out_Valid !== 1'b1 || Mux_Out !== 32'd23) begin errors++; $display("FAIL flush_after: got v=%0b d=%0d want v=1 d=23", Out_Valid, Mux_Out); end
    $display("txn flush: post-flush out=%0d", Mux_Out);
    step();
    checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL flush_after_drain: got %0b want 0", Out_Valid); end
  endtask

  // Sel=3 with N=3 stores slice 0; Sel_Err depends on the build.
  task automatic test_out_of_range();
    idle();
    checks++; if (Sel_Err !== 1'b0) begin errors++; $display("FAIL oob_pre: got %0b want 0", Sel_Err); end
    set_data(32'd7, 32'd8, 32'd9); Sel = 2'd3; In_Valid = 1'b1;
    step();
    In_Valid = 1'b0;
    checks++; if (Out_Valid !== 1'b1 || Mux_Out !== 32'd7) begin errors++; $display("FAIL oob_data: got v=%0b d=%0d want v=1 d=7", Out_Valid, Mux_Out); end
    checks++; if (Sel_Err !== SEL_CHK) begin errors++; $display("FAIL oob_err_set: got %0b want %0b", Sel_Err, SEL_CHK); end
    $display("txn oob: sel=3 out=%0d sel_err=%0b", Mux_Out, Sel_Err);
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    checks++; if (Sel_Err !== SEL_CHK) begin errors++; $display("FAIL oob_err_flush: got %0b want %0b", Sel_Err, SEL_CHK); end
    Sel = 2'd2; In_Valid = 1'b1;
    step();
    In_Valid = 1'b0;
    checks++; if (Mux_Out !== 32'd9 || Sel_Err !== SEL_CHK) begin errors++; $display("FAIL oob_inrange: got d=%0d err=%0b want d=9 err=%0b", Mux_Out, Sel_Err, SEL_CHK); end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    checks++; if (Sel_Err !== 1'b0) begin errors++; $display("FAIL oob_err_reset: got %0b want 0", Sel_Err); end
  endtask

  // 100 consecutive accepts with Out_Ready=1: one output per cycle, latency 1.
  task automatic test_back_to_back();
    logic [WIDTH-1:0] d0, d1, d2, exp_d;
    logic [SEL_W-1:0] s;
    int               outs;
    int               ready_miss;
    outs = 0; ready_miss = 0;
    idle();
    for (int i = 0; i < 100; i++) begin
      d0 = $urandom; d1 = $urandom; d2 = $urandom;
      s  = SEL_W'($urandom_range(0, 3));
      case (s)
        2'd1:    exp_d = d1;
        2'd2:    exp_d = d2;
        default: exp_d = d0;   // codes 0 and 3 both read slice 0
      endcase
      set_data(d0, d1, d2); Sel = s; In_Valid = 1'b1;
      if (In_Ready !== 1'b1) ready_miss++;
      step();
      checks++;
      if (Out_Valid !== 1'b1 || Mux_Out !== exp_d) begin
        errors++; $display("FAIL b2b_%0d: got v=%0b d=%h want v=1 d=%h", i, Out_Valid, Mux_Out, exp_d);
      end else begin
        outs++;
      end
      $display("txn b2b %0d: sel=%0d out=%h", i, s, Mux_Out);
    end
    In_Valid = 1'b0;
    checks++; if (ready_miss !== 0) begin errors++; $display("FAIL b2b_ready: got %0d stalled cycles want 0", ready_miss); end
    step();
    checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL b2b_tail: got %0b want 0", Out_Valid); end
    checks++; if (outs !== 100) begin errors++; $display("FAIL b2b_count: got %0d outputs want 100", outs); end
  endtask

  initial begin
    test_reset();
    test_basic_select();
    test_stall_skid();
    test_flush();
    test_out_of_range();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
